// File: rtl/axi_rd_pkg.sv
// Shared burst/response encodings, the queued AR entry layout and the burst legality helper
// used by the axi_rd_burst_slave block.
package axi_rd_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  // Widest ID/address the entry can carry; narrower instances zero-extend into it.
  localparam int AR_ID_W_MAX   = 16;
  localparam int AR_ADDR_W_MAX = 64;

  typedef struct packed {
    logic [AR_ID_W_MAX-1:0]   id;
    logic [AR_ADDR_W_MAX-1:0] addr;
    logic [7:0]               len;
    logic [1:0]               burst;
  } ar_entry_t;

  // Reserved burst type, or a WRAP whose beat count is not 2, 4, 8 or 16.
  function automatic logic ar_slverr(input logic [1:0] burst, input logic [7:0] len);
    return (burst == 2'd3) ||
           ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

endpackage

// File: rtl/axi_ar_fifo.sv
// Read-address queue: power-of-two depth FIFO with full/empty flags and
// first-word-fall-through output so the burst engine can pop in one cycle.
module axi_ar_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr_reg;
  logic [PW:0]      rd_ptr_reg;

  // Extra pointer bit separates the full and empty cases when the indices match.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                 (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign dout  = mem[rd_ptr_reg[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr_reg[PW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push && !full) wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
    end
  end

endmodule

// File: rtl/axi_rd_burst_slave.sv
// AXI4 read-channel slave: queues AR requests and streams FIXED/INCR/WRAP bursts from a
// combinational word memory. Define AXI_RD_RANGE_CHK_EN to return DECERR above MEM_SIZE_BYTES.
module axi_rd_burst_slave
  import axi_rd_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int AR_DEPTH       = 4,
  parameter int MEM_SIZE_BYTES = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  input  logic [1:0]            arburst,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int NB      = DATA_WIDTH / 8;
  localparam int NB_LOG2 = $clog2(NB);
  localparam logic [ADDR_WIDTH-1:0] NB_A       = ADDR_WIDTH'(NB);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(NB - 1);
`ifdef AXI_RD_RANGE_CHK_EN
  localparam logic [ADDR_WIDTH:0]   MEM_LIMIT  = (ADDR_WIDTH+1)'(MEM_SIZE_BYTES);
`endif

  generate
    if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0 ||
        AR_DEPTH < 2 || (AR_DEPTH & (AR_DEPTH - 1)) != 0 ||
        ID_WIDTH < 1 || ID_WIDTH > AR_ID_W_MAX ||
        ADDR_WIDTH < 8 || ADDR_WIDTH > AR_ADDR_W_MAX || MEM_SIZE_BYTES < 1) begin : g_bad_cfg
      $error("axi_rd_burst_slave: unsupported parameter combination");
    end
  endgenerate

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state_reg;
  logic                  ar_en_reg;
  logic [ID_WIDTH-1:0]   cur_id_reg;
  logic [ADDR_WIDTH-1:0] cur_addr_reg;
  logic [7:0]            cur_len_reg;
  logic [1:0]            cur_burst_reg;
  logic                  cur_err_reg;
  logic [7:0]            beat_reg;
  logic [ID_WIDTH-1:0]   rid_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic [1:0]            rresp_reg;
  logic                  rlast_reg;
  logic                  rvalid_reg;

  ar_entry_t             push_entry;
  ar_entry_t             pop_entry;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  r_load;
  logic                  last_beat;
  logic [1:0]            beat_resp;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  unused_entry_bits;

  assign arready   = ar_en_reg && !fifo_full;
  assign fifo_push = arvalid && arready;

  always_comb begin
    push_entry       = '0;
    push_entry.id    = AR_ID_W_MAX'(arid);
    push_entry.addr  = AR_ADDR_W_MAX'(araddr & ALIGN_MASK);
    push_entry.len   = arlen;
    push_entry.burst = arburst;
  end

  axi_ar_fifo #(
    .WIDTH ($bits(ar_entry_t)),
    .DEPTH (AR_DEPTH)
  ) u_ar_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .din    (push_entry),
    .pop    (fifo_pop),
    .dout   (pop_entry),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Entry bits above the configured ID/address widths are always zero.
  assign unused_entry_bits = ^{pop_entry.id, pop_entry.addr};

  assign r_load    = (state_reg == BURST) && (!rvalid_reg || rready);
  assign last_beat = (beat_reg == cur_len_reg);
  // Popping on the last beat keeps consecutive bursts bubble-free.
  assign fifo_pop  = !fifo_empty && ((state_reg == IDLE) || (r_load && last_beat));

  assign incr_addr = cur_addr_reg + NB_A;
  assign wrap_mask = ((ADDR_WIDTH'(cur_len_reg) + ADDR_WIDTH'(1)) << NB_LOG2) - ADDR_WIDTH'(1);

  always_comb begin
    next_addr = incr_addr;
    case (cur_burst_reg)
      BURST_FIXED: next_addr = cur_addr_reg;
      BURST_WRAP:  next_addr = (cur_addr_reg & ~wrap_mask) | (incr_addr & wrap_mask);
      default:     next_addr = incr_addr;
    endcase
  end

  always_comb begin
    beat_resp = RESP_OKAY;
    if (cur_err_reg) beat_resp = RESP_SLVERR;
`ifdef AXI_RD_RANGE_CHK_EN
    else if ({1'b0, cur_addr_reg} >= MEM_LIMIT) beat_resp = RESP_DECERR;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      ar_en_reg     <= 1'b0;
      cur_id_reg    <= '0;
      cur_addr_reg  <= '0;
      cur_len_reg   <= '0;
      cur_burst_reg <= BURST_FIXED;
      cur_err_reg   <= 1'b0;
      beat_reg      <= '0;
      rid_reg       <= '0;
      rdata_reg     <= '0;
      rresp_reg     <= RESP_OKAY;
      rlast_reg     <= 1'b0;
      rvalid_reg    <= 1'b0;
    end else begin
      ar_en_reg <= 1'b1;
      if (rready) rvalid_reg <= 1'b0;
      if (r_load) begin
        rvalid_reg   <= 1'b1;
        rid_reg      <= cur_id_reg;
        rresp_reg    <= beat_resp;
        rdata_reg    <= (beat_resp == RESP_OKAY) ? mem_rdata : '0;
        rlast_reg    <= last_beat;
        cur_addr_reg <= next_addr;
        beat_reg     <= beat_reg + 8'd1;
        if (last_beat && fifo_empty) state_reg <= IDLE;
      end
      if (fifo_pop) begin
        cur_id_reg    <= pop_entry.id[ID_WIDTH-1:0];
        cur_addr_reg  <= pop_entry.addr[ADDR_WIDTH-1:0];
        cur_len_reg   <= pop_entry.len;
        cur_burst_reg <= pop_entry.burst;
        cur_err_reg   <= ar_slverr(pop_entry.burst, pop_entry.len);
        beat_reg      <= '0;
        state_reg     <= BURST;
      end
    end
  end

  assign rid       = rid_reg;
  assign rdata     = rdata_reg;
  assign rresp     = rresp_reg;
  assign rlast     = rlast_reg;
  assign rvalid    = rvalid_reg;
  assign mem_raddr = cur_addr_reg;

endmodule
